// File: rtl/rfphoenix_fetch_packer_pkg.sv
// Shared types and encodings for the rfPhoenix fetch packer and its decode-side buffer.
package rfphoenix_fetch_packer_pkg;

   localparam int unsigned PC_W       = 32;
   localparam int unsigned INSN_BYTES = 5;

   typedef struct packed {
      logic [5:0] rsv;
      logic [2:0] pad;
      logic [5:0] func;
      logic [5:0] rb;
      logic [5:0] ra;
      logic [5:0] rt;
      logic [6:0] opcode;
   } instruction_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      instruction_t    pfx;
      instruction_t    insn;
   } InstructionFetchbuf;

   typedef enum logic {ST_IDLE, ST_PFX_HELD} pack_state_e;

   localparam logic [6:0] OP_NOP  = 7'h00;
   localparam logic [6:0] OP_R2   = 7'h02;
   localparam logic [6:0] OP_ADDI = 7'h04;
   localparam logic [6:0] OP_PFX  = 7'h7C;
   localparam logic [5:0] VSLLVI  = 6'h24;
   localparam logic [5:0] SYS_RA  = 6'd63;
   localparam logic [5:0] SYS_RB  = 6'd1;
   localparam logic [2:0] FLT_PAD = 3'b000;
   localparam logic [2:0] IRQ_PAD = 3'b100;

   localparam instruction_t NOP_INSN = instruction_t'({33'd0, OP_NOP});

   // FLT and IRQ share one R2 form and differ only in pad.
   function automatic instruction_t sys_insn(input logic [2:0] pad);
      instruction_t w;
      w        = NOP_INSN;
      w.opcode = OP_R2;
      w.ra     = SYS_RA;
      w.func   = VSLLVI;
      w.rb     = SYS_RB;
      w.pad    = pad;
      return w;
   endfunction

endpackage

// File: rtl/rfphoenix_ifb_fifo.sv
// Synchronous DEPTH-entry FIFO of InstructionFetchbuf entries; head reads as zero when empty.
module rfphoenix_ifb_fifo
   import rfphoenix_fetch_packer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  InstructionFetchbuf       wdata,
   output InstructionFetchbuf       rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   InstructionFetchbuf mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   cnt;
   logic               do_push;
   logic               do_pop;

   assign full    = (cnt == CNT_W'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // Storage needs no reset; the empty flag masks stale contents.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/rfphoenix_fetch_packer.sv
// Packs fetch words into decode entries: merges PFX words, injects FLT/IRQ forms, buffers in a FIFO.
// Optional RFPHOENIX_IFB_BYPASS_EN presents a word straight to decode when the FIFO is empty.
module rfphoenix_fetch_packer
   import rfphoenix_fetch_packer_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned INSN_W = 40
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   fch_valid_i,
   output logic                   fch_ready_o,
   input  logic [PC_W-1:0]        fch_pc_i,
   input  logic [INSN_W-1:0]      fch_insn_i,
   input  logic                   fch_err_i,
   input  logic                   irq_i,
   output logic                   irq_ack_o,
   output logic                   ifb_valid_o,
   input  logic                   ifb_ready_i,
   output InstructionFetchbuf     ifb_o,
   output logic [$clog2(DEPTH):0] count_o
);

   instruction_t       fch_word;
   pack_state_e        state_r;
   instruction_t       pfx_r;
   logic [PC_W-1:0]    next_pc_r;
   logic               live_r;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;
   logic               room;
   logic               irq_inject;
   logic               xfer;
   logic               is_pfx;
   logic               emit;
   logic               bypass;
   InstructionFetchbuf fetch_entry;
   InstructionFetchbuf fifo_wdata;
   InstructionFetchbuf fifo_rdata;

   assign fch_word = instruction_t'(fch_insn_i);

`ifdef RFPHOENIX_IFB_BYPASS_EN
   assign bypass = fifo_empty && emit;
`else
   assign bypass = 1'b0;
`endif

   assign ifb_valid_o = !fifo_empty || bypass;
   assign ifb_o       = fifo_empty ? (bypass ? fetch_entry : '0) : fifo_rdata;
   assign fifo_pop    = !fifo_empty && ifb_ready_i;
   assign room        = !fifo_full || fifo_pop;

   // IRQ only between instructions, never splitting a PFX from its target.
   assign irq_inject  = live_r && irq_i && (state_r == ST_IDLE) && room && !flush_i;
   assign irq_ack_o   = irq_inject;
   assign fch_ready_o = live_r && !flush_i && !irq_inject && room;
   assign xfer        = fch_valid_i && fch_ready_o;
   assign is_pfx      = (fch_word.opcode == OP_PFX);
   assign emit        = xfer && (fch_err_i || !is_pfx);

   always_comb begin
      fetch_entry.pc   = fch_pc_i;
      fetch_entry.pfx  = (state_r == ST_PFX_HELD) ? pfx_r : NOP_INSN;
      fetch_entry.insn = fch_word;
      if (fch_err_i) begin
         fetch_entry.pfx  = NOP_INSN;
         fetch_entry.insn = sys_insn(FLT_PAD);
      end
   end

   assign fifo_push  = irq_inject || (emit && !(bypass && ifb_ready_i));
   assign fifo_wdata = irq_inject ? '{pc: next_pc_r, pfx: NOP_INSN, insn: sys_insn(IRQ_PAD)}
                                  : fetch_entry;

   // Prefix tracking FSM; live_r holds off fetch until the first edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         pfx_r     <= NOP_INSN;
         next_pc_r <= '0;
         live_r    <= 1'b0;
      end else begin
         live_r <= 1'b1;
         if (flush_i) begin
            state_r <= ST_IDLE;
            pfx_r   <= NOP_INSN;
         end else if (xfer) begin
            next_pc_r <= fch_pc_i + PC_W'(INSN_BYTES);
            if (!fch_err_i && is_pfx) begin
               state_r <= ST_PFX_HELD;
               pfx_r   <= fch_word;
            end else begin
               state_r <= ST_IDLE;
               pfx_r   <= NOP_INSN;
            end
         end
      end
   end

   rfphoenix_ifb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (flush_i),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count_o)
   );

endmodule

// File: tb/tb_rfphoenix_fetch_packer.sv
// Scoreboard bench for rfphoenix_fetch_packer: directed scenarios plus randomized traffic.
`timescale 1ns/1ps
module tb_rfphoenix_fetch_packer;
   import rfphoenix_fetch_packer_pkg::*;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned INSN_W = 40;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   flush_i = 1'b0;
   logic                   fch_valid_i = 1'b0;
   logic                   fch_ready_o;
   logic [31:0]            fch_pc_i = '0;
   logic [INSN_W-1:0]      fch_insn_i = '0;
   logic                   fch_err_i = 1'b0;
   logic                   irq_i = 1'b0;
   logic                   irq_ack_o;
   logic                   ifb_valid_o;
   logic                   ifb_ready_i = 1'b0;
   InstructionFetchbuf     ifb_o;
   logic [$clog2(DEPTH):0] count_o;

   rfphoenix_fetch_packer #(.DEPTH(DEPTH), .INSN_W(INSN_W)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .fch_valid_i(fch_valid_i), .fch_ready_o(fch_ready_o), .fch_pc_i(fch_pc_i),
      .fch_insn_i(fch_insn_i), .fch_err_i(fch_err_i), .irq_i(irq_i), .irq_ack_o(irq_ack_o),
      .ifb_valid_o(ifb_valid_o), .ifb_ready_i(ifb_ready_i), .ifb_o(ifb_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   int unsigned        n_checks = 0;
   int unsigned        n_fail = 0;
   InstructionFetchbuf exp_q[$];
   bit                 m_held = 1'b0;
   instruction_t       m_pfx;
   logic [31:0]        m_next_pc = '0;
   logic [31:0]        last_imm = '0;

   function automatic instruction_t mk_i(input logic [6:0] op, input logic [15:0] imm,
                                         input logic [5:0] ra, input logic [5:0] rt);
      logic [39:0] w;
      w = {imm, 5'd0, ra, rt, op};
      return instruction_t'(w);
   endfunction

   function automatic instruction_t nop_w();
      logic [39:0] w;
      w = 40'd0;
      return instruction_t'(w);
   endfunction

   function automatic instruction_t sys_word(input logic [2:0] pad);
      logic [39:0] w;
      // pad | func | rb | ra | rt | opcode, with R2 opcode 7'h02, VSLLVI 6'h24
      w = {6'd0, pad, 6'h24, 6'd1, 6'd63, 6'd0, 7'h02};
      return instruction_t'(w);
   endfunction

   function automatic logic [15:0] imm16(input instruction_t i);
      logic [39:0] w;
      w = i;
      return w[39:24];
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc, input instruction_t pfx, input instruction_t insn);
      InstructionFetchbuf e;
      e.pc   = pc;
      e.pfx  = pfx;
      e.insn = insn;
      exp_q.push_back(e);
   endtask

   // One clock of stimulus; the reference model decides handshakes from queue occupancy.
   task automatic cycle(input logic v, input logic [31:0] pc, input instruction_t w,
                        input logic err, input logic irq, input logic fl, input logic rdy);
      int sz;
      bit room, inj, exp_rdy, xf;
      @(negedge clk);
      fch_valid_i = v; fch_pc_i = pc; fch_insn_i = w; fch_err_i = err;
      irq_i = irq; flush_i = fl; ifb_ready_i = rdy;
      #1;
      sz      = exp_q.size();
      room    = (sz < int'(DEPTH)) || (sz > 0 && rdy);
      inj     = irq && !m_held && room && !fl;
      exp_rdy = !fl && !inj && room;
      xf      = v && exp_rdy;
      check("fch_ready", 128'(fch_ready_o), 128'(exp_rdy));
      check("irq_ack", 128'(irq_ack_o), 128'(inj));
      #2;
      if (fl) begin
         exp_q.delete();
         m_held = 1'b0;
         m_pfx  = nop_w();
      end else if (inj) begin
         push_exp(m_next_pc, nop_w(), sys_word(3'b100));
      end else if (xf) begin
         m_next_pc = pc + 32'd5;
         if (err) begin
            push_exp(pc, nop_w(), sys_word(3'b000));
            m_held = 1'b0;
            m_pfx  = nop_w();
         end else if (w.opcode == OP_PFX) begin
            m_held = 1'b1;
            m_pfx  = w;
         end else begin
            push_exp(pc, m_held ? m_pfx : nop_w(), w);
            m_held = 1'b0;
            m_pfx  = nop_w();
         end
      end
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, nop_w(), 1'b0, 1'b0, 1'b0, rdy);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_fch_ready"}, 128'(fch_ready_o), 128'(0));
      check({tag, "_ifb_valid"}, 128'(ifb_valid_o), 128'(0));
      check({tag, "_irq_ack"}, 128'(irq_ack_o), 128'(0));
      check({tag, "_count"}, 128'(count_o), 128'(0));
      check({tag, "_ifb"}, 128'(ifb_o), 128'(0));
   endtask

   // Monitor: compares occupancy and every popped entry against the scoreboard queue.
   initial begin
      int sz;
      InstructionFetchbuf e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            sz = exp_q.size();
            check("count", 128'(count_o), 128'(sz));
            check("ifb_valid", 128'(ifb_valid_o), 128'(sz != 0));
            if (sz != 0 && ifb_ready_i) begin
               e = exp_q.pop_front();
               check("ifb_entry", 128'(ifb_o), 128'(e));
               if (e.pfx.opcode == OP_PFX) last_imm = {imm16(ifb_o.pfx), imm16(ifb_o.insn)};
            end
         end
      end
   end

   initial begin
      instruction_t w;
      logic [15:0]  imm;
      m_pfx = nop_w();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      #5 rst = 1'b0;
      @(posedge clk);

      // Plain stream, one-cycle latency, pfx NOP
      cycle(1'b1, 32'd0,  mk_i(OP_ADDI, 16'd1, 6'd1, 6'd2), 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'd5,  mk_i(OP_ADDI, 16'd2, 6'd1, 6'd2), 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'd10, mk_i(OP_ADDI, 16'd3, 6'd1, 6'd2), 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b1);

      // PFX merge into the following ADDI
      cycle(1'b1, 32'd20, mk_i(OP_PFX, 16'h1234, 6'd0, 6'd0), 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'd25, mk_i(OP_ADDI, 16'h0010, 6'd3, 6'd4), 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b1);
      check("prefixed_imm", 128'(last_imm), 128'(32'h12340010));

      // Back-pressure: six offered, four accepted, then drain
      for (int i = 0; i < 6; i++)
         cycle(1'b1, 32'(100 + 5 * i), mk_i(OP_ADDI, 16'(i), 6'd5, 6'd6), 1'b0, 1'b0, 1'b0, 1'b0);
      idle(6, 1'b1);

      // IRQ held off while a PFX waits for its target
      cycle(1'b1, 32'h200, mk_i(OP_PFX, 16'hBEEF, 6'd0, 6'd0), 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'h205, mk_i(OP_ADDI, 16'h0001, 6'd1, 6'd1), 1'b0, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 32'h20A, mk_i(OP_ADDI, 16'h0002, 6'd1, 6'd1), 1'b0, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 32'h20A, mk_i(OP_ADDI, 16'h0002, 6'd1, 6'd1), 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b1);

      // Fault while a prefix is held, then IRQ proves the FSM is idle again
      cycle(1'b1, 32'h0FB, mk_i(OP_PFX, 16'h5555, 6'd0, 6'd0), 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'h100, mk_i(OP_ADDI, 16'h7777, 6'd2, 6'd2), 1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 32'd0, nop_w(), 1'b0, 1'b1, 1'b0, 1'b1);
      idle(3, 1'b1);

      // Flush with three buffered, a held PFX and a push offered in the same cycle
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'(300 + 5 * i), mk_i(OP_ADDI, 16'(i), 6'd7, 6'd7), 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'd315, mk_i(OP_PFX, 16'hAAAA, 6'd0, 6'd0), 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'd320, mk_i(OP_ADDI, 16'h0009, 6'd7, 6'd7), 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1, 1'b0);
      cycle(1'b1, 32'd400, mk_i(OP_ADDI, 16'h000A, 6'd7, 6'd7), 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b1);

      // Randomized traffic with alternating back-pressure phases
      for (int i = 0; i < 1500; i++) begin
         imm = 16'($urandom);
         if ($urandom_range(0, 3) == 0) w = mk_i(OP_PFX, imm, 6'd0, 6'd0);
         else w = mk_i(OP_ADDI, imm, 6'($urandom), 6'($urandom));
         cycle(1'($urandom_range(0, 9) < 8), 32'($urandom), w,
               1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) == 0),
               1'($urandom_range(0, 39) == 0),
               1'($urandom_range(0, 9) < ((i % 200) < 100 ? 3 : 8)));
      end
      idle(8, 1'b1);

      // Asynchronous reset mid-operation
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'(500 + 5 * i), mk_i(OP_ADDI, 16'(i), 6'd1, 6'd1), 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'd515, mk_i(OP_PFX, 16'h4321, 6'd0, 6'd0), 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #4 rst = 1'b1;
      #1;
      fch_valid_i = 1'b0; irq_i = 1'b0; ifb_ready_i = 1'b0; flush_i = 1'b0;
      check_reset_outputs("midreset");
      exp_q.delete();
      m_held = 1'b0; m_pfx = nop_w(); m_next_pc = '0;
      @(negedge clk);
      #5 rst = 1'b0;
      @(posedge clk);
      cycle(1'b1, 32'd600, mk_i(OP_ADDI, 16'h00FF, 6'd1, 6'd1), 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 32'd0, nop_w(), 1'b0, 1'b1, 1'b0, 1'b1);
      idle(3, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
